npu_result_writeback: RTL and testbench

//  Sink end of the PE result stream: captures o_valid/o_result pulses from npu_pe and

---
 rtl/npu_pkg.sv | 10 +
 rtl/npu_sync_fifo.sv | 47 ++++
 rtl/npu_result_writeback.sv | 122 ++++++++++++
 tb/tb_npu_result_writeback.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and default widths for the NPU result path.
package npu_pkg;

  typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_DONE} wb_state_t;

  localparam int NPU_DATA_W     = 8;
  localparam int NPU_ADDR_W     = 8;
  localparam int NPU_FIFO_DEPTH = 4;

endpackage

// File: rtl/npu_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and a flush input.
module npu_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/npu_result_writeback.sv
// Drains the PE result stream into a memory write port, one word per cycle,
// from a start address for a fixed count; lost results raise a sticky flag.
module npu_result_writeback
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = NPU_DATA_W,
  parameter int ADDR_WIDTH = NPU_ADDR_W,
  parameter int FIFO_DEPTH = NPU_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_count,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_result,
  output logic                  o_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  wb_state_t             state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] accepted;
  logic [ADDR_WIDTH-1:0] written;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  room;
  logic                  push;
  logic                  pop;
  logic                  flush;

  assign room  = (accepted != count);
  assign push  = (state == WB_RUN) && i_valid && !fifo_full && room;
  assign pop   = (state == WB_RUN) && !fifo_empty;
  assign flush = (state == WB_IDLE) && i_start;

  assign o_ready = !fifo_full && (state == WB_RUN) && room;
  assign o_busy  = (state == WB_RUN);

  npu_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .data (i_result),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  // Any strobe that is not pushed is a lost result, whatever the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WB_IDLE;
      ptr        <= '0;
      count      <= '0;
      accepted   <= '0;
      written    <= '0;
      o_we       <= 1'b0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        WB_IDLE: begin
          o_we   <= 1'b0;
          o_done <= 1'b0;
          if (i_start) begin
            ptr        <= i_base_addr;
            count      <= i_count;
            accepted   <= '0;
            written    <= '0;
            o_overflow <= 1'b0;
            state      <= (i_count != '0) ? WB_RUN : WB_DONE;
          end else if (i_valid) begin
            o_overflow <= 1'b1;
          end
        end
        WB_RUN: begin
          o_done <= 1'b0;
          if (push) accepted <= accepted + ONE;
          if (i_valid && !push) o_overflow <= 1'b1;
          if (pop) begin
            o_we    <= 1'b1;
            o_addr  <= ptr;
            o_wdata <= fifo_head;
            ptr     <= ptr + ONE;
            written <= written + ONE;
            if ((written + ONE) == count) state <= WB_DONE;
          end else begin
            o_we <= 1'b0;
          end
        end
        WB_DONE: begin
          o_we   <= 1'b0;
          o_done <= 1'b1;
          state  <= WB_IDLE;
          if (i_valid) o_overflow <= 1'b1;
        end
        default: begin
          o_we  <= 1'b0;
          state <= WB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_result_writeback.sv
// Randomized bench for npu_result_writeback against a run-level reference model.
module tb_npu_result_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_base_addr;
  logic [7:0] i_count;
  logic       i_valid;
  logic [7:0] i_result;
  logic       o_ready;
  logic       o_we;
  logic [7:0] o_addr;
  logic [7:0] o_wdata;
  logic       o_busy;
  logic       o_done;
  logic       o_overflow;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         wr_cyc_q  [$];
  int         done_cyc_q[$];
  logic       busy_seen;

  npu_result_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_base_addr(i_base_addr),
    .i_count    (i_count),
    .i_valid    (i_valid),
    .i_result   (i_result),
    .o_ready    (o_ready),
    .o_we       (o_we),
    .o_addr     (o_addr),
    .o_wdata    (o_wdata),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are observed on the falling edge, tagged with the number of rising edges so far.
  always @(negedge clk) begin
    if (o_we) begin
      wr_addr_q.push_back(o_addr);
      wr_data_q.push_back(o_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (o_done) done_cyc_q.push_back(cyc);
    if (o_busy) busy_seen = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearLogs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    busy_seen = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_outputs"},
                32'({o_ready, o_we, o_addr, o_wdata, o_busy, o_done, o_overflow}), 32'd0);
  endtask

  // One run: start, nres results (random gaps among the counted ones, extras back-to-back),
  // then compare the observed writes and done pulse with the model's expectations.
  task automatic applyStimulus(input logic [7:0] base, input logic [7:0] cnt,
                               input int nres, input int gap_max);
    int         s;
    int         vcyc[$];
    logic [7:0] vdat[$];
    logic [7:0] d;
    int         n_exp;
    int         waited;
    int         exp_done;
    clearLogs();
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = base;
    i_count     = cnt;
    s           = cyc + 1;
    @(negedge clk);
    i_start     = 1'b0;
    i_base_addr = 8'($urandom);
    i_count     = 8'($urandom);
    checkOutput("overflow_cleared_on_start", 32'(o_overflow), 32'd0);
    checkOutput("busy_after_start", 32'(o_busy), 32'(cnt != 0));
    checkOutput("ready_after_start", 32'(o_ready), 32'(cnt != 0));
    for (int i = 0; i < nres; i++) begin
      if (i < int'(cnt) && gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      d        = 8'($urandom);
      i_valid  = 1'b1;
      i_result = d;
      vcyc.push_back(cyc + 1);
      vdat.push_back(d);
      @(negedge clk);
      i_valid = 1'b0;
    end
    waited = 0;
    while (done_cyc_q.size() == 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);

    n_exp = (nres < int'(cnt)) ? nres : int'(cnt);
    exp_done = (n_exp == 0) ? s + 1 : vcyc[n_exp-1] + 2;
    checkOutput("write_count", 32'(wr_addr_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < wr_addr_q.size(); i++) begin
      checkOutput($sformatf("addr[%0d]", i), 32'(wr_addr_q[i]), 32'(8'(base + 8'(i))));
      checkOutput($sformatf("data[%0d]", i), 32'(wr_data_q[i]), 32'(vdat[i]));
      checkOutput($sformatf("latency[%0d]", i), 32'(wr_cyc_q[i]), 32'(vcyc[i] + 1));
    end
    checkOutput("done_pulses", 32'(done_cyc_q.size()), 32'd1);
    if (done_cyc_q.size() > 0) checkOutput("done_cycle", 32'(done_cyc_q[0]), 32'(exp_done));
    checkOutput("overflow", 32'(o_overflow), 32'(nres > int'(cnt)));
    checkOutput("busy_seen", 32'(busy_seen), 32'(cnt != 0));
  endtask

  initial begin
    int cnt;
    rst         = 1'b1;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_count     = '0;
    i_valid     = 1'b0;
    i_result    = '0;
    clearLogs();
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("idle");

    $display("[TB] directed: basic run");
    applyStimulus(8'h10, 8'd4, 4, 0);
    $display("[TB] directed: address wrap");
    applyStimulus(8'hFE, 8'd3, 3, 0);
    $display("[TB] directed: zero count");
    applyStimulus(8'h33, 8'd0, 0, 0);
    $display("[TB] directed: extra result");
    applyStimulus(8'h20, 8'd2, 3, 0);
    repeat (5) @(negedge clk);
    checkOutput("overflow_sticky", 32'(o_overflow), 32'd1);

    $display("[TB] directed: idle strobe");
    applyStimulus(8'h50, 8'd1, 1, 0);
    clearLogs();
    i_valid  = 1'b1;
    i_result = 8'hA5;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_valid_overflow", 32'(o_overflow), 32'd1);
    checkOutput("idle_valid_no_write", 32'(wr_addr_q.size()), 32'd0);
    applyStimulus(8'h60, 8'd1, 1, 0);

    $display("[TB] directed: reset mid-run");
    clearLogs();
    @(negedge clk);
    i_start     = 1'b1;
    i_base_addr = 8'h40;
    i_count     = 8'd4;
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid  = 1'b1;
      i_result = 8'(8'h70 + 8'(i));
      @(negedge clk);
    end
    i_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    checkAllZero("mid_reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkAllZero("after_reset");
    checkOutput("writes_before_reset", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() >= 2) begin
      checkOutput("reset_run_addr1", 32'(wr_addr_q[1]), 32'h41);
      checkOutput("reset_run_data1", 32'(wr_data_q[1]), 32'h71);
    end
    checkOutput("no_done_after_reset", 32'(done_cyc_q.size()), 32'd0);
    applyStimulus(8'h00, 8'd1, 1, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 12; r++) begin
      cnt = $urandom_range(9, 1);
      applyStimulus(8'($urandom), 8'(cnt), cnt + ((r % 3 == 0) ? $urandom_range(2, 1) : 0),
                    $urandom_range(2, 0));
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
